// File: rtl/tmds_channel_decoder_if.sv
// Lane-side bundle of the TMDS channel decoder: raw deserialized word in,
// decoded pixel/control/alignment status out.
interface tmds_channel_decoder_if;
    logic [9:0] tmds_in;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       de;
    logic       locked;
    logic [3:0] bit_offset;

    modport master (
        output tmds_in,
        input  data, ctrl, de, locked, bit_offset
    );

    modport slave (
        input  tmds_in,
        output data, ctrl, de, locked, bit_offset
    );
endinterface

// File: rtl/tmds_channel_decoder.sv
// One TMDS lane receiver: finds word alignment by hunting for runs of control
// tokens, then decodes aligned 10-bit words into pixel data / control / de.
module tmds_channel_decoder #(
    parameter int unsigned CTRL_RUN       = 8,
    parameter int unsigned SEARCH_TIMEOUT = 64,
    parameter int unsigned LOCK_TIMEOUT   = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    tmds_channel_decoder_if.slave  bus
);

    localparam int unsigned RUN_W     = $clog2(CTRL_RUN) + 1;
    localparam int unsigned TIMER_MAX = (LOCK_TIMEOUT > SEARCH_TIMEOUT) ? LOCK_TIMEOUT : SEARCH_TIMEOUT;
    localparam int unsigned TIMER_W   = $clog2(TIMER_MAX) + 1;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state, state_n;
    logic [9:0]         prev;
    logic [RUN_W-1:0]   run, run_n;
    logic [TIMER_W-1:0] timer, timer_n;
    logic [3:0]         offset, offset_n;
    logic [7:0]         data_r, data_n;
    logic [1:0]         ctrl_r, ctrl_n;
    logic               de_r, de_n;

    logic [19:0] win;
    logic [9:0]  word;
    logic        is_token;
    logic [1:0]  token_val;
    logic [7:0]  q;
    logic [7:0]  decoded;

    // Two-word window lets any of the ten bit phases be pulled out as a word.
    assign win  = {bus.tmds_in, prev};
    assign word = 10'(win >> offset);

    always_comb begin
        is_token  = 1'b1;
        token_val = 2'b00;
        case (word)
            10'b1101010100: token_val = 2'b00;
            10'b0010101011: token_val = 2'b01;
            10'b0101010100: token_val = 2'b10;
            10'b1010101011: token_val = 2'b11;
            default:        is_token  = 1'b0;
        endcase
    end

    // Undo the optional inversion, then the XOR/XNOR transition chain.
    always_comb begin
        q          = word[9] ? ~word[7:0] : word[7:0];
        decoded    = '0;
        decoded[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            decoded[i] = word[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
    end

    always_comb begin
        state_n  = state;
        run_n    = run;
        timer_n  = timer;
        offset_n = offset;
        data_n   = data_r;
        ctrl_n   = ctrl_r;
        de_n     = de_r;

        case (state)
            SEARCH: begin
                if (is_token) begin
                    timer_n = '0;
                    if (run == RUN_W'(CTRL_RUN - 1)) begin
                        state_n = LOCKED;
                        run_n   = '0;
                    end else begin
                        run_n = run + RUN_W'(1);
                    end
                end else begin
                    run_n = '0;
                    if (timer == TIMER_W'(SEARCH_TIMEOUT - 1)) begin
                        timer_n  = '0;
                        offset_n = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
                    end else begin
                        timer_n = timer + TIMER_W'(1);
                    end
                end
            end
            LOCKED: begin
                if (is_token) begin
                    timer_n = '0;
                end else if (timer == TIMER_W'(LOCK_TIMEOUT - 1)) begin
                    state_n = SEARCH;
                    timer_n = '0;
                    run_n   = '0;
                end else begin
                    timer_n = timer + TIMER_W'(1);
                end
            end
            default: state_n = SEARCH;
        endcase

        // Outputs follow the lock state being entered so they drop with locked.
        if (state_n != LOCKED) begin
            de_n   = 1'b0;
            data_n = '0;
            ctrl_n = '0;
        end else if (is_token) begin
            de_n   = 1'b0;
            ctrl_n = token_val;
        end else begin
            de_n   = 1'b1;
            data_n = decoded;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= SEARCH;
            prev   <= '0;
            run    <= '0;
            timer  <= '0;
            offset <= '0;
            data_r <= '0;
            ctrl_r <= '0;
            de_r   <= 1'b0;
        end else begin
            state  <= state_n;
            prev   <= bus.tmds_in;
            run    <= run_n;
            timer  <= timer_n;
            offset <= offset_n;
            data_r <= data_n;
            ctrl_r <= ctrl_n;
            de_r   <= de_n;
        end
    end

    assign bus.data       = data_r;
    assign bus.ctrl       = ctrl_r;
    assign bus.de         = de_r;
    assign bus.locked     = (state == LOCKED);
    assign bus.bit_offset = offset;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder: stimulus pushes expected outputs
// tagged with the cycle they should appear; a monitor pops and checks them.
module tb_tmds_channel_decoder;

    localparam logic [9:0] TOK00 = 10'h354;
    localparam logic [9:0] TOK01 = 10'h0AB;
    localparam logic [9:0] TOK10 = 10'h154;
    localparam logic [9:0] TOK11 = 10'h2AB;

    typedef struct packed {
        logic       locked;
        logic       de;
        logic [7:0] data;
        logic [1:0] ctrl;
        logic [3:0] off;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tmds_channel_decoder_if bus();

    tmds_channel_decoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    obs_t        exp_q[$];
    int unsigned cyc_q[$];
    string       name_q[$];

    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic        done = 1'b0;
    logic        drained = 1'b0;
    logic [9:0]  last_w = '0;
    int unsigned shift_k = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Stream is modelled as a bit sequence; shift_k places word boundaries.
    task automatic send(input logic [9:0] w);
        logic [19:0] cat;
        cat         = {w, last_w};
        bus.tmds_in = 10'(cat >> (10 - shift_k));
        last_w      = w;
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string nm, input logic l, input logic d,
                            input logic [7:0] dt, input logic [1:0] c, input logic [3:0] o);
        exp_q.push_back(obs_t'({l, d, dt, c, o}));
        cyc_q.push_back(cyc);
        name_q.push_back(nm);
    endtask

    task automatic hold_reset(input int n);
        rst = 1'b0;
        repeat (n) send(10'($urandom));
        rst = 1'b1;
    endtask

    // Monitor: compare every queued expectation on the cycle it is due.
    initial begin
        obs_t        act_v;
        obs_t        exp_v;
        int unsigned c_v;
        string       nm_v;
        forever begin
            @(negedge clk);
            act_v = {bus.locked, bus.de, bus.data, bus.ctrl, bus.bit_offset};
            while (exp_q.size() != 0 && (cyc_q[0] <= cyc || done)) begin
                exp_v = exp_q.pop_front();
                c_v   = cyc_q.pop_front();
                nm_v  = name_q.pop_front();
                total++;
                if (c_v != cyc) begin
                    bad++;
                    $display("FAIL %s: due at cycle %0d, checked at cycle %0d", nm_v, c_v, cyc);
                end else if (act_v !== exp_v) begin
                    bad++;
                    $display("FAIL %s: got locked=%b de=%b data=%h ctrl=%b off=%0d, want locked=%b de=%b data=%h ctrl=%b off=%0d",
                             nm_v, act_v.locked, act_v.de, act_v.data, act_v.ctrl, act_v.off,
                             exp_v.locked, exp_v.de, exp_v.data, exp_v.ctrl, exp_v.off);
                end
            end
            if (done) drained = 1'b1;
        end
    end

    initial begin
        rst         = 1'b0;
        bus.tmds_in = '0;

        // Reset with random input
        hold_reset(3);
        push_exp("reset_state", 1'b0, 1'b0, 8'h00, 2'b00, 4'd0);

        // Aligned stream: aligned word lags the sent word by one cycle
        repeat (8) send(TOK00);
        push_exp("pre_lock", 1'b0, 1'b0, 8'h00, 2'b00, 4'd0);
        send(10'h100); push_exp("lock_ctrl00",   1'b1, 1'b0, 8'h00, 2'b00, 4'd0);
        send(10'h2FF); push_exp("data_00",       1'b1, 1'b1, 8'h00, 2'b00, 4'd0);
        send(10'h1F0); push_exp("data_fe",       1'b1, 1'b1, 8'hFE, 2'b00, 4'd0);
        send(10'h0F0); push_exp("data_10",       1'b1, 1'b1, 8'h10, 2'b00, 4'd0);
        send(10'h2C3); push_exp("data_ee",       1'b1, 1'b1, 8'hEE, 2'b00, 4'd0);
        send(TOK01);   push_exp("data_ba",       1'b1, 1'b1, 8'hBA, 2'b00, 4'd0);
        send(TOK10);   push_exp("ctrl01_hold",   1'b1, 1'b0, 8'hBA, 2'b01, 4'd0);
        send(10'h100); push_exp("ctrl10_hold",   1'b1, 1'b0, 8'hBA, 2'b10, 4'd0);
        send(10'h100); push_exp("data_keepctrl", 1'b1, 1'b1, 8'h00, 2'b10, 4'd0);

        // Broken run of tokens must not lock
        hold_reset(1);
        repeat (7) send(TOK11);
        send(10'h100);
        push_exp("run7_no_lock", 1'b0, 1'b0, 8'h00, 2'b00, 4'd0);
        repeat (7) send(TOK11);
        push_exp("run_broken", 1'b0, 1'b0, 8'h00, 2'b00, 4'd0);
        send(TOK11);
        push_exp("run7_again", 1'b0, 1'b0, 8'h00, 2'b00, 4'd0);
        send(10'h100);
        push_exp("lock_ctrl11", 1'b1, 1'b0, 8'h00, 2'b11, 4'd0);

        // Stream shifted by 3 bits: offset hunts 0,1,2,3 then locks
        hold_reset(1);
        shift_k = 3;
        last_w  = TOK10;
        for (int i = 1; i <= 200; i++) begin
            send(TOK10);
            case (i)
                1, 63:    push_exp("search_off0", 1'b0, 1'b0, 8'h00, 2'b00, 4'd0);
                64, 127:  push_exp("search_off1", 1'b0, 1'b0, 8'h00, 2'b00, 4'd1);
                128, 191: push_exp("search_off2", 1'b0, 1'b0, 8'h00, 2'b00, 4'd2);
                192, 199: push_exp("search_off3", 1'b0, 1'b0, 8'h00, 2'b00, 4'd3);
                200:      push_exp("lock_off3",   1'b1, 1'b0, 8'h00, 2'b10, 4'd3);
                default: ;
            endcase
        end

        // Lock loss after a long data-only stretch, then relock in place
        for (int i = 1; i <= 4097; i++) begin
            send(10'h1AA);
            case (i)
                1:    push_exp("last_token",   1'b1, 1'b0, 8'h00, 2'b10, 4'd3);
                2:    push_exp("shifted_data", 1'b1, 1'b1, 8'hFE, 2'b10, 4'd3);
                4096: push_exp("pre_drop",     1'b1, 1'b1, 8'hFE, 2'b10, 4'd3);
                4097: push_exp("lock_drop",    1'b0, 1'b0, 8'h00, 2'b00, 4'd3);
                default: ;
            endcase
        end
        for (int i = 1; i <= 9; i++) begin
            send(TOK10);
            if (i == 8) push_exp("relock_pending", 1'b0, 1'b0, 8'h00, 2'b00, 4'd3);
            if (i == 9) push_exp("relock_off3",    1'b1, 1'b0, 8'h00, 2'b10, 4'd3);
        end

        // Reset while locked and streaming data
        send(10'h1AA); push_exp("tok_before_rst", 1'b1, 1'b0, 8'h00, 2'b10, 4'd3);
        send(10'h1AA); push_exp("data_before_rst", 1'b1, 1'b1, 8'hFE, 2'b10, 4'd3);
        rst = 1'b0;
        send(10'h1AA);
        rst = 1'b1;
        push_exp("mid_reset", 1'b0, 1'b0, 8'h00, 2'b00, 4'd0);
        for (int i = 1; i <= 200; i++) begin
            send(TOK10);
            case (i)
                100: push_exp("research_off1", 1'b0, 1'b0, 8'h00, 2'b00, 4'd1);
                199: push_exp("research_off3", 1'b0, 1'b0, 8'h00, 2'b00, 4'd3);
                200: push_exp("research_lock", 1'b1, 1'b0, 8'h00, 2'b10, 4'd3);
                default: ;
            endcase
        end

        send(TOK10);
        done = 1'b1;
        for (int i = 0; i < 4 && !drained; i++) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
